// File: rtl/ray_gen_sched_if.sv
// Issue bus between the frame scheduler and the ray generator.
// Handshake: op_vld is a one-cycle issue strobe with no ready. The ray
// generator takes every beat. Flow control is by credits only: credit_ret
// pulses once per ray drained from the downstream FIFO.
interface ray_gen_sched_if #(
    parameter int PX_WIDTH  = 9,
    parameter int PY_WIDTH  = 8,
    parameter int RPP_WIDTH = 2
);
    logic                 op_vld;
    logic [PX_WIDTH-1:0]  x;
    logic [PY_WIDTH-1:0]  y;
    logic [RPP_WIDTH-1:0] s;
    logic                 credit_ret;

    modport master (output op_vld, output x, output y, output s, input credit_ret);
    modport slave  (input op_vld, input x, input y, input s, output credit_ret);
endinterface

// File: rtl/ray_gen_sched.sv
// Frame-level issue scheduler: walks every (x, y, sample) tuple once per
// frame. Each issue consumes a credit. After the last issue it waits for
// all credits to come back, then pulses done.
module ray_gen_sched #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int RPP       = 4,
    parameter int CREDITS   = 16,
    parameter int PX_WIDTH  = 9,
    parameter int PY_WIDTH  = 8,
    parameter int RPP_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    ray_gen_sched_if.master        iss,
    output logic                   busy,
    output logic                   done,
    output logic                   credit_err,
    output logic [1:0]             state_dbg,
    output logic [7:0]             credits_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [PX_WIDTH-1:0]  LAST_X   = PX_WIDTH'(IMG_W - 1);
    localparam logic [PY_WIDTH-1:0]  LAST_Y   = PY_WIDTH'(IMG_H - 1);
    localparam logic [RPP_WIDTH-1:0] LAST_S   = RPP_WIDTH'(RPP - 1);
    localparam logic [7:0]           CRED_MAX = 8'(CREDITS);

    state_e               state_q, state_d;
    // cx/cy/cs hold the next tuple to issue; x/y/s hold the last issued one
    logic [PX_WIDTH-1:0]  cx_q, cx_d, x_q, x_d;
    logic [PY_WIDTH-1:0]  cy_q, cy_d, y_q, y_d;
    logic [RPP_WIDTH-1:0] cs_q, cs_d, s_q, s_d;
    logic                 vld_q, vld_d;
    logic [7:0]           credits_q, credits_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 issue;
    logic                 last_tuple;

    // A return in the same cycle covers an issue even at zero credits
    assign issue      = (state_q == ST_RUN) && ((credits_q != 8'd0) || iss.credit_ret);
    assign last_tuple = (cx_q == LAST_X) && (cy_q == LAST_Y) && (cs_q == LAST_S);

    // Next-state, tuple walk, credit accounting and registered output values
    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        cs_d      = cs_q;
        x_d       = x_q;
        y_d       = y_q;
        s_d       = s_q;
        vld_d     = 1'b0;
        credits_d = credits_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cx_d    = '0;
                    cy_d    = '0;
                    cs_d    = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    vld_d = 1'b1;
                    x_d   = cx_q;
                    y_d   = cy_q;
                    s_d   = cs_q;
                    if (cs_q == LAST_S) begin
                        cs_d = '0;
                        if (cx_q == LAST_X) begin
                            cx_d = '0;
                            cy_d = (cy_q == LAST_Y) ? '0 : cy_q + 1'b1;
                        end else begin
                            cx_d = cx_q + 1'b1;
                        end
                    end else begin
                        cs_d = cs_q + 1'b1;
                    end
                    if (last_tuple) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (credits_q == CRED_MAX) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue && !iss.credit_ret) begin
            credits_d = credits_q - 8'd1;
        end else if (iss.credit_ret && !issue) begin
            if (credits_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 8'd1;
            end
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            cs_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            s_q       <= '0;
            vld_q     <= 1'b0;
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            cs_q      <= cs_d;
            x_q       <= x_d;
            y_q       <= y_d;
            s_q       <= s_d;
            vld_q     <= vld_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign iss.op_vld  = vld_q;
    assign iss.x       = x_q;
    assign iss.y       = y_q;
    assign iss.s       = s_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign credit_err  = err_q;
    assign state_dbg   = state_q;
    assign credits_dbg = credits_q;

endmodule

// File: tb/tb_ray_gen_sched.sv
// Bench for ray_gen_sched: two 4x2x2 instances, A with 16 credits and a
// 3-cycle credit loopback, B with 2 credits and hand-driven returns.
module tb_ray_gen_sched;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int R     = 2;
    localparam int TOTAL = W * H * R;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, start_b = 1'b0;
    logic man_ret_a = 1'b0, man_ret_b = 1'b0;
    logic loop_en = 1'b0;
    logic [2:0] pipe;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [1:0] st_a, st_b;
    logic [7:0] cr_a, cr_b;

    ray_gen_sched_if #(.PX_WIDTH(2), .PY_WIDTH(1), .RPP_WIDTH(1)) bus_a ();
    ray_gen_sched_if #(.PX_WIDTH(2), .PY_WIDTH(1), .RPP_WIDTH(1)) bus_b ();

    ray_gen_sched #(.IMG_W(W), .IMG_H(H), .RPP(R), .CREDITS(16),
                    .PX_WIDTH(2), .PY_WIDTH(1), .RPP_WIDTH(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .iss(bus_a.master),
        .busy(busy_a), .done(done_a), .credit_err(err_a),
        .state_dbg(st_a), .credits_dbg(cr_a));

    ray_gen_sched #(.IMG_W(W), .IMG_H(H), .RPP(R), .CREDITS(2),
                    .PX_WIDTH(2), .PY_WIDTH(1), .RPP_WIDTH(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .iss(bus_b.master),
        .busy(busy_b), .done(done_b), .credit_err(err_b),
        .state_dbg(st_b), .credits_dbg(cr_b));

    // Downstream FIFO stand-in for A: each ray is consumed 3 cycles after issue
    assign bus_a.credit_ret = loop_en ? pipe[2] : man_ret_a;
    assign bus_b.credit_ret = man_ret_b;
    always @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[1:0], bus_a.op_vld};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Phase 0 idle, 1 run, 2 drain, 3 done. The frame is a linear tuple
    // index decoded into (x, y, s) with s fastest and y slowest.
    int m_phase[2], m_idx[2], m_cred[2];
    bit m_err[2], e_vld[2], e_busy[2], e_done[2];
    int e_x[2], e_y[2], e_s[2];

    function automatic int cmax(input int i);
        return (i == 0) ? 16 : 2;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit st, rt, did;
            int ph;
            st = (i == 0) ? start_a : start_b;
            rt = (i == 0) ? bus_a.credit_ret : bus_b.credit_ret;
            if (rst) begin
                m_phase[i] = 0; m_idx[i] = 0; m_cred[i] = cmax(i); m_err[i] = 0;
                e_vld[i] = 0; e_x[i] = 0; e_y[i] = 0; e_s[i] = 0;
                e_busy[i] = 0; e_done[i] = 0;
            end else begin
                ph  = m_phase[i];
                did = (ph == 1) && ((m_cred[i] > 0) || rt);
                e_vld[i] = did;
                if (did) begin
                    e_s[i] = m_idx[i] % R;
                    e_x[i] = (m_idx[i] / R) % W;
                    e_y[i] = m_idx[i] / (R * W);
                end
                case (ph)
                    0: if (st) begin m_phase[i] = 1; m_idx[i] = 0; end
                    1: if (did) begin
                           m_idx[i]++;
                           if (m_idx[i] == TOTAL) m_phase[i] = 2;
                       end
                    2: if (m_cred[i] == cmax(i)) m_phase[i] = 3;
                    default: m_phase[i] = 0;
                endcase
                if (did && !rt) m_cred[i]--;
                else if (rt && !did) begin
                    if (m_cred[i] == cmax(i)) m_err[i] = 1;
                    else m_cred[i]++;
                end
                e_busy[i] = (m_phase[i] == 1) || (m_phase[i] == 2);
                e_done[i] = (m_phase[i] == 3);
            end
        end
    end

    // Per-cycle compare of both DUTs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_vld", bus_a.op_vld, e_vld[0]);
            chk("a_busy", busy_a, e_busy[0]);
            chk("a_done", done_a, e_done[0]);
            chk("a_err", err_a, m_err[0]);
            chk("a_credits", cr_a, m_cred[0]);
            chk("a_state", st_a, m_phase[0]);
            if (e_vld[0]) begin
                chk("a_x", bus_a.x, e_x[0]);
                chk("a_y", bus_a.y, e_y[0]);
                chk("a_s", bus_a.s, e_s[0]);
            end
            chk("b_vld", bus_b.op_vld, e_vld[1]);
            chk("b_busy", busy_b, e_busy[1]);
            chk("b_done", done_b, e_done[1]);
            chk("b_err", err_b, m_err[1]);
            chk("b_credits", cr_b, m_cred[1]);
            chk("b_state", st_b, m_phase[1]);
            if (e_vld[1]) begin
                chk("b_x", bus_b.x, e_x[1]);
                chk("b_y", bus_b.y, e_y[1]);
                chk("b_s", bus_b.s, e_s[1]);
            end
        end
    end

    // Beat and done monitors
    int nbeat_a = 0, nbeat_b = 0, ndone_a = 0, ndone_b = 0;
    int tup_a[$], cyc_a[$];
    always @(negedge clk) begin
        if (bus_a.op_vld === 1'b1) begin
            nbeat_a++;
            tup_a.push_back(int'(bus_a.x) * 4 + int'(bus_a.y) * 2 + int'(bus_a.s));
            cyc_a.push_back(cyc);
        end
        if (bus_b.op_vld === 1'b1) nbeat_b++;
        if (done_a === 1'b1) ndone_a++;
        if (done_b === 1'b1) ndone_b++;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_beats(input int which, input int target, input int budget, input string name);
        int g;
        g = 0;
        while ((((which == 0) ? nbeat_a : nbeat_b) < target) && (g < budget)) begin
            tick();
            g++;
        end
        chk(name, (((which == 0) ? nbeat_a : nbeat_b) >= target), 1);
    endtask

    task automatic wait_done(input int which, input int target, input int budget, input string name);
        int g;
        g = 0;
        while ((((which == 0) ? ndone_a : ndone_b) < target) && (g < budget)) begin
            tick();
            g++;
        end
        chk(name, (((which == 0) ? ndone_a : ndone_b) >= target), 1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Expected free-run order, packed as x*4 + y*2 + s
    int exp_ord[16] = '{0, 1, 4, 5, 8, 9, 12, 13, 2, 3, 6, 7, 10, 11, 14, 15};

    initial begin
        int base, dbase, lat;

        // reset
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_vld_a", bus_a.op_vld, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_cred_a", cr_a, 16);
        chk("rst_cred_b", cr_b, 2);
        chk("rst_xys_a", {bus_a.x, bus_a.y, bus_a.s}, 0);
        rst = 1'b0;
        tick();

        // free run with loopback, plus starts during RUN and DRAIN
        loop_en = 1'b1;
        base  = nbeat_a;
        dbase = ndone_a;
        pulse_start_a();
        lat = 1;
        while (!bus_a.op_vld && lat < 50) begin
            tick();
            lat++;
        end
        chk("start_latency", lat, 2);
        wait_beats(0, base + 5, 50, "run_5_beats");
        pulse_start_a();
        wait_beats(0, base + TOTAL, 50, "run_all_beats");
        chk("drain_after_last", st_a, 2);
        pulse_start_a();
        wait_done(0, dbase + 1, 100, "free_done");
        repeat (5) tick();
        chk("free_beat_count", nbeat_a - base, 16);
        chk("free_done_count", ndone_a - dbase, 1);
        chk("free_err", err_a, 0);
        chk("free_contiguous", cyc_a[base + 15] - cyc_a[base], 15);
        for (int k = 0; k < 16; k++) chk("free_order", tup_a[base + k], exp_ord[k]);

        // credit starvation on B; cycle 0 is the start cycle
        base  = nbeat_b;
        dbase = ndone_b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        chk("starve_beats", nbeat_b - base, 2);
        chk("starve_vld", bus_b.op_vld, 0);
        chk("starve_cred", cr_b, 0);
        man_ret_b = 1'b1;
        tick();
        man_ret_b = 1'b0;
        chk("ret20_vld", bus_b.op_vld, 1);
        chk("ret20_tuple", {bus_b.x, bus_b.y, bus_b.s}, 4);
        chk("ret20_cred", cr_b, 0);
        tick();
        chk("ret20_single", bus_b.op_vld, 0);
        man_ret_b = 1'b1;
        for (int c = 0; c < 15; c++) tick();
        man_ret_b = 1'b0;
        wait_done(1, dbase + 1, 20, "starve_done");
        repeat (3) tick();
        chk("starve_total", nbeat_b - base, 16);
        chk("starve_done_count", ndone_b - dbase, 1);
        chk("starve_err", err_b, 0);

        // reset mid-frame after 5 issues, then restart
        base = nbeat_a;
        pulse_start_a();
        wait_beats(0, base + 5, 50, "abort_5_beats");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_vld", bus_a.op_vld, 0);
        chk("abort_xys", {bus_a.x, bus_a.y, bus_a.s}, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_err", err_a, 0);
        chk("abort_cred", cr_a, 16);
        chk("abort_state", st_a, 0);
        chk("abort_count", nbeat_a - base, 5);
        base  = nbeat_a;
        dbase = ndone_a;
        pulse_start_a();
        wait_beats(0, base + 1, 20, "restart_beat");
        chk("restart_first", tup_a[base], 0);
        wait_done(0, dbase + 1, 100, "restart_done");
        repeat (3) tick();
        chk("restart_total", nbeat_a - base, 16);

        // extra return in IDLE with full credits: sticky error
        loop_en   = 1'b0;
        man_ret_a = 1'b1;
        tick();
        man_ret_a = 1'b0;
        chk("err_set", err_a, 1);
        chk("err_cred", cr_a, 16);
        tick();
        chk("err_sticky", err_a, 1);
        loop_en = 1'b1;
        dbase = ndone_a;
        pulse_start_a();
        wait_done(0, dbase + 1, 100, "err_frame_done");
        tick();
        chk("err_after_frame", err_a, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", err_a, 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
